// File: rtl/uart_rx_sampler_if.sv
// Shared frame-config types and the bit-stream bundle between uart_rx_sampler and uart_rx.
// The sampler drives the master side; uart_rx consumes the slave side.
package uart_rx_sampler_pkg;
    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_ODD  = 2'd1,
        PARITY_EVEN = 2'd2
    } parity_t;

    typedef enum logic {
        STOP_BITS_1 = 1'b0,
        STOP_BITS_2 = 1'b1
    } stop_bits_t;
endpackage

interface uart_rx_sampler_if;
    logic bit_strobe;
    logic bit_value;
    logic frame_start;
    logic frame_done;
    logic framing_error;
    logic false_start;
    logic busy;
    logic break_det;

    modport master (
        output bit_strobe, bit_value, frame_start, frame_done,
               framing_error, false_start, busy, break_det
    );

    modport slave (
        input  bit_strobe, bit_value, frame_start, frame_done,
               framing_error, false_start, busy, break_det
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// UART receive front end: rx synchronizer, start validation, mid-bit 3-sample majority vote.
// Optional line-break detection is enabled with the macro UART_RX_SAMPLER_BREAK_DETECT_EN.
module uart_rx_sampler
    import uart_rx_sampler_pkg::*;
#(
    parameter int DIV_W   = 16,
    parameter int MIN_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_in,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic [3:0]        num_data_bits,
    input  parity_t           parity,
    input  stop_bits_t        stop_bits,
    uart_rx_sampler_if.master rx_bits
);

`ifdef UART_RX_SAMPLER_BREAK_DETECT_EN
    typedef enum logic [1:0] {IDLE, START, DATA, BREAK} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA} state_t;
`endif

    function automatic logic maj3(input logic [2:0] h);
        return (h[0] & h[1]) | (h[0] & h[2]) | (h[1] & h[2]);
    endfunction

    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        return (d < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : d;
    endfunction

    function automatic logic [3:0] frame_len(input logic [3:0] nd, input parity_t p,
                                             input stop_bits_t s);
        logic [3:0] n;
        n = (nd < 4'd5) ? 4'd5 : ((nd > 4'd8) ? 4'd8 : nd);
        return 4'd1 + n + ((p != PARITY_NONE) ? 4'd1 : 4'd0) + ((s == STOP_BITS_2) ? 4'd2 : 4'd1);
    endfunction

    logic [1:0]       sync_q;
    logic [2:0]       hist_q;
    logic             rx_s;
    logic             vote;
    state_t           state_q, state_d;
    logic [DIV_W-1:0] cyc_q, cyc_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       idx_q, idx_d;
    logic [3:0]       fbits_q, fbits_d;
    logic             stop2_q, stop2_d;
    logic             ferr_q, ferr_d;
    logic             strobe_q, strobe_d;
    logic             value_q, value_d;
    logic             fstart_q, fstart_d;
    logic             done_q, done_d;
    logic             ferr_out_q, ferr_out_d;
    logic             fs_q, fs_d;
    logic             busy_q, busy_d;
    logic             stop_bit;
    logic             last_bit;
    logic             ferr_now;
`ifdef UART_RX_SAMPLER_BREAK_DETECT_EN
    logic             ones_q, ones_d;
    logic             brk_q, brk_d;
`endif

    assign rx_s     = sync_q[1];
    assign vote     = maj3(hist_q);
    assign stop_bit = idx_q >= (fbits_q - (stop2_q ? 4'd2 : 4'd1));
    assign last_bit = idx_q == (fbits_q - 4'd1);
    assign ferr_now = ferr_q | (stop_bit & ~vote);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
            hist_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[0], rx_in};
            hist_q <= {hist_q[1:0], rx_s};
        end
    end

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        idx_d      = idx_q;
        div_d      = div_q;
        fbits_d    = fbits_q;
        stop2_d    = stop2_q;
        ferr_d     = ferr_q;
        strobe_d   = 1'b0;
        value_d    = 1'b0;
        fstart_d   = 1'b0;
        done_d     = 1'b0;
        ferr_out_d = 1'b0;
        fs_d       = 1'b0;
`ifdef UART_RX_SAMPLER_BREAK_DETECT_EN
        ones_d     = ones_q;
        brk_d      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cyc_d   = '0;
                    idx_d   = 4'd0;
                    ferr_d  = 1'b0;
                    div_d   = clamp_div(baud_div);
                    fbits_d = frame_len(num_data_bits, parity, stop_bits);
                    stop2_d = (stop_bits == STOP_BITS_2);
`ifdef UART_RX_SAMPLER_BREAK_DETECT_EN
                    ones_d  = 1'b0;
`endif
                end
            end
            START: begin
                if (cyc_q == ((div_q >> 1) - DIV_W'(1))) begin
                    cyc_d = '0;
                    if (vote) begin
                        fs_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        strobe_d = 1'b1;
                        fstart_d = 1'b1;
                        idx_d    = 4'd1;
                        state_d  = DATA;
                    end
                end else begin
                    cyc_d = cyc_q + DIV_W'(1);
                end
            end
            DATA: begin
                if (cyc_q == (div_q - DIV_W'(1))) begin
                    strobe_d = 1'b1;
                    value_d  = vote;
                    cyc_d    = '0;
                    idx_d    = idx_q + 4'd1;
                    ferr_d   = ferr_now;
`ifdef UART_RX_SAMPLER_BREAK_DETECT_EN
                    ones_d   = ones_q | vote;
`endif
                    // Leave mid-stop-bit so a start bit right after the stop bit is seen
                    if (last_bit) begin
                        done_d     = 1'b1;
                        ferr_out_d = ferr_now;
                        state_d    = IDLE;
`ifdef UART_RX_SAMPLER_BREAK_DETECT_EN
                        if (!ones_q && !vote) begin
                            brk_d   = 1'b1;
                            state_d = BREAK;
                        end
`endif
                    end
                end else begin
                    cyc_d = cyc_q + DIV_W'(1);
                end
            end
`ifdef UART_RX_SAMPLER_BREAK_DETECT_EN
            BREAK: begin
                // Require a full bit period of idle line before re-arming
                if (!rx_s) begin
                    cyc_d = '0;
                end else if (cyc_q == (div_q - DIV_W'(1))) begin
                    cyc_d   = '0;
                    state_d = IDLE;
                end else begin
                    cyc_d = cyc_q + DIV_W'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == DATA) | done_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cyc_q      <= '0;
            idx_q      <= 4'd0;
            div_q      <= '0;
            fbits_q    <= 4'd0;
            stop2_q    <= 1'b0;
            ferr_q     <= 1'b0;
            strobe_q   <= 1'b0;
            value_q    <= 1'b0;
            fstart_q   <= 1'b0;
            done_q     <= 1'b0;
            ferr_out_q <= 1'b0;
            fs_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            idx_q      <= idx_d;
            div_q      <= div_d;
            fbits_q    <= fbits_d;
            stop2_q    <= stop2_d;
            ferr_q     <= ferr_d;
            strobe_q   <= strobe_d;
            value_q    <= value_d;
            fstart_q   <= fstart_d;
            done_q     <= done_d;
            ferr_out_q <= ferr_out_d;
            fs_q       <= fs_d;
            busy_q     <= busy_d;
        end
    end

`ifdef UART_RX_SAMPLER_BREAK_DETECT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ones_q <= 1'b0;
            brk_q  <= 1'b0;
        end else begin
            ones_q <= ones_d;
            brk_q  <= brk_d;
        end
    end
    assign rx_bits.break_det = brk_q;
`else
    assign rx_bits.break_det = 1'b0;
`endif

    assign rx_bits.bit_strobe    = strobe_q;
    assign rx_bits.bit_value     = value_q;
    assign rx_bits.frame_start   = fstart_q;
    assign rx_bits.frame_done    = done_q;
    assign rx_bits.framing_error = ferr_out_q;
    assign rx_bits.false_start   = fs_q;
    assign rx_bits.busy          = busy_q;

endmodule
